serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning operand/sum width in bits (>=2).
REQ-002 The module SHALL have parameter DIGIT, default 4, meaning bits added per cycle; DIGIT SHALL divide WIDTH, with NDIG = WIDTH/DIGIT.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port start  input  1  request to begin an addition; sampled only while ready=1.
REQ-006 The module SHALL have ports a and b  input  WIDTH  operands, captured on the accepted start edge.
REQ-007 The module SHALL have port cin  input  1  carry-in, captured with a and b.
REQ-008 The module SHALL have port ready  output  1  high when start will be accepted.
REQ-009 The module SHALL have port busy  output  1  high while digits are being added.
REQ-010 The module SHALL have port done  output  1  single-cycle pulse marking a new valid result.
REQ-011 The module SHALL have port sum  output  WIDTH  result register, a+b+cin modulo 2^WIDTH.
REQ-012 The module SHALL have port cout  output  1  carry-out of the MSB.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 IDLE: ready=1, busy=0, done=0; start=1 captures a, b, cin, clears the digit counter, and moves to RUN.
REQ-015 RUN: ready=0, busy=1; each edge adds one DIGIT-bit slice LSB-first with the registered carry, stores the partial sum, and advances the counter.
REQ-016 After the NDIG-th RUN edge, the FSM SHALL load sum/cout from the partial registers and move to DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, ready=1 and busy=0; start=1 there starts a new operation (back-to-back), otherwise the next state is IDLE.
REQ-018 Latency SHALL be fixed: done is high in the cycle after NDIG+1 rising edges counted from the edge that accepted start.
REQ-019 start while busy=1 SHALL be ignored and SHALL NOT alter the captured operands.
REQ-020 sum/cout SHALL hold the last completed result and change only on the edge entering DONE.
REQ-021 NDIG=1 (DIGIT=WIDTH) SHALL be legal: RUN lasts one cycle.
REQ-022 The carry SHALL propagate between digits with no wrap; a carry out of the last digit becomes cout.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE and set sum=0, cout=0, done=0, busy=0, ready=1, and clear the carry and counter registers.
REQ-024 Reset during RUN SHALL abort the operation; no done pulse SHALL follow release.

Configuration
REQ-025 With SERIAL_ADDER_OVF_EN defined, the module SHALL add output port ovf (1 bit): signed two's-complement overflow, computed as the XOR of the carries into and out of the MSB, updated with sum, and reset to 0.
REQ-026 Without SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL be absent.

Structure
REQ-027 A shared package serial_adder_pkg SHALL hold the state enum typedef and the default WIDTH/DIGIT constants.
REQ-028 The per-cycle slice adder SHALL be the sub-module digit_adder (DIGIT-bit ripple of full adders, with cin/cout), instantiated once.

Verification (WIDTH=16, DIGIT=4 unless noted)
REQ-029 a=0x0000, b=0x0000, cin=0 -> sum=0x0000, cout=0; done high after 5 edges from the start edge.
REQ-030 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
REQ-031 With a=0x1234, b=0x1111 accepted, pulse start with a=0xFFFF mid-RUN -> start ignored; result sum=0x2345.
REQ-032 Assert rst_n=0 in the 2nd RUN cycle -> outputs at reset values immediately; no done pulse; next start operates normally.
REQ-033 Start held high in DONE -> back-to-back ops; done pulses every 5 cycles; sums 0x000A+0x0005 -> 0x000F, then 0x8000+0x8000 -> 0x0000, cout=1.
REQ-034 With SERIAL_ADDER_OVF_EN: 0x7FFF+0x0001 -> ovf=1; 0xFFFF+0x0001 -> ovf=0. With WIDTH=8, DIGIT=8: 0xA5+0x5A, cin=1 -> sum=0x00, cout=1, done after 2 edges.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module : serial_adder_pkg
// Brief  : Shared state encoding and default geometry for serial_adder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIGIT = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_adder_digit_adder.sv
// ============================================================================
// Module : digit_adder
// Brief  : W-bit ripple-carry adder built from full adders, with carry in/out.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module digit_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar i = 0; i < W; i++) begin : g_fa
            assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
            assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = w_c[W];

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module : serial_adder
// Brief  : Digit-serial adder, DIGIT bits per cycle, LSB first.
//          Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_psum;
    logic [WIDTH-1:0] w_psum_next;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;
    logic [DIGIT-1:0] w_dsum;
    logic             w_dcout;
    logic             w_last;
    logic             w_accept;

    assign w_da     = r_a[int'(r_cnt) * DIGIT +: DIGIT];
    assign w_db     = r_b[int'(r_cnt) * DIGIT +: DIGIT];
    assign w_last   = (r_cnt == CW'(NDIG - 1));
    assign w_accept = start && (r_state != S_RUN);

    digit_adder #(
        .W (DIGIT)
    ) u_digit_adder (
        .a    (w_da),
        .b    (w_db),
        .cin  (r_carry),
        .sum  (w_dsum),
        .cout (w_dcout)
    );

    // Partial sum with the current digit merged in, so the final RUN edge can
    // publish the complete result without an extra cycle.
    always_comb begin
        w_psum_next = r_psum;
        w_psum_next[int'(r_cnt) * DIGIT +: DIGIT] = w_dsum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_next = start ? S_RUN : S_IDLE;
            S_RUN:   w_state_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b1;
        busy  = 1'b0;
        done  = 1'b0;
        case (r_state)
            S_RUN: begin
                ready = 1'b0;
                busy  = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_psum  <= w_psum_next;
            r_carry <= w_dcout;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                sum  <= w_psum_next;
                cout <= w_dcout;
`ifdef SERIAL_ADDER_OVF_EN
                // Carry into the MSB is recovered from the MSB sum bit.
                ovf  <= w_dcout ^ (w_da[DIGIT-1] ^ w_db[DIGIT-1] ^ w_dsum[DIGIT-1]);
`endif
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module : tb_serial_adder
// Brief  : Self-checking bench for serial_adder (16/4 and 8/8 instances).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, cin, start8, cin8;
    logic [15:0] a, b;
    logic [7:0]  a8, b8;
    logic        ready, busy, done, cout;
    logic [15:0] sum;
    logic        ready8, busy8, done8, cout8;
    logic [7:0]  sum8;
`ifdef SERIAL_ADDER_OVF_EN
    logic        ovf, ovf8;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .ready (ready8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counts edges from the accepting edge (which counts as 1) until done is seen.
    // Optionally pulses a bogus start with garbage operands in the 2nd RUN cycle.
    task automatic wait_done(input bit inject, output int n);
        n = 1;
        forever begin
            @(negedge clk);
            if (done) break;
            if (n > 20) begin
                check("timeout", 32'd0, 32'd1);
                break;
            end
            check("busy_in_run", {31'd0, busy}, 32'd1);
            if (inject && n == 2) begin
                start = 1'b1;
                a     = 16'hFFFF;
                b     = 16'hFFFF;
                cin   = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            n++;
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] xa,
                                input logic [15:0] xb, input logic xc);
        logic [16:0] full;
        full = {1'b0, xa} + {1'b0, xb} + {16'd0, xc};
        check({tag, "_sum"},  {16'd0, sum},  {16'd0, full[15:0]});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, full[16]});
`ifdef SERIAL_ADDER_OVF_EN
        begin
            int s;
            s = int'($signed(xa)) + int'($signed(xb)) + int'(xc);
            check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, (s > 32767 || s < -32768)});
        end
`endif
    endtask

    task automatic do_op(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                         input logic xc, input bit inject);
        int n;
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        a = xa; b = xb; cin = xc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        wait_done(inject, n);
        check({tag, "_lat"}, n, 32'd5);
        check_result(tag, xa, xb, xc);
        check({tag, "_rdy_done"}, {30'd0, ready, busy}, 32'd2);
        @(negedge clk);
        check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    endtask

    task automatic do_op8(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                          input logic xc);
        int n;
        logic [8:0] full;
        full = {1'b0, xa} + {1'b0, xb} + {8'd0, xc};
        @(negedge clk);
        a8 = xa; b8 = xb; cin8 = xc; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        n = 1;
        forever begin
            @(negedge clk);
            if (done8) break;
            if (n > 20) begin
                check("timeout8", 32'd0, 32'd1);
                break;
            end
            @(posedge clk);
            n++;
        end
        check({tag, "_lat"},  n, 32'd2);
        check({tag, "_sum"},  {24'd0, sum8},  {24'd0, full[7:0]});
        check({tag, "_cout"}, {31'd0, cout8}, {31'd0, full[8]});
    endtask

    initial begin
        int n;
        bit seen;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        #12;
        check("rst_sum",   {16'd0, sum}, 32'd0);
        check("rst_flags", {28'd0, ready, busy, done, cout}, 32'h8);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("zero", 16'h0000, 16'h0000, 1'b0, 1'b0);
        do_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_op("ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        do_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        do_op("ignore", 16'h1234, 16'h1111, 1'b0, 1'b1);
        check("ignore_exact", {16'd0, sum}, 32'h2345);

        // Abort in the 2nd RUN cycle: outputs drop to reset values at once.
        do_op("pre_abort", 16'h1234, 16'h4321, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sum",   {16'd0, sum}, 32'd0);
        check("abort_flags", {28'd0, ready, busy, done, cout}, 32'h8);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", {31'd0, seen}, 32'd0);
        do_op("post_abort", 16'h0F0F, 16'h0101, 1'b1, 1'b0);

        // Back-to-back with start held through DONE.
        @(negedge clk);
        a = 16'h000A; b = 16'h0005; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 a = 16'h8000; b = 16'h8000;
        wait_done(1'b0, n);
        check("b2b1_lat", n, 32'd5);
        check_result("b2b1", 16'h000A, 16'h0005, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(1'b0, n);
        check("b2b2_lat", n, 32'd5);
        check_result("b2b2", 16'h8000, 16'h8000, 1'b0);

        for (int i = 0; i < 20; i++) begin
            do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
        end

        do_op8("d8", 8'hA5, 8'h5A, 1'b1);
        for (int i = 0; i < 5; i++) begin
            do_op8("rand8", 8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
